fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl_if.sv | 24 ++
 rtl/fir_seq_ctrl.sv | 97 +++++++++
 tb/tb_fir_seq_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - sample, coefficient and result handshakes of the sequential FIR
interface fir_seq_ctrl_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] x;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic signed [7:0] cfg_data;
    logic              cfg_err;
    logic              out_valid;
    logic              out_ready;
    logic signed [15:0] y;
    logic              busy;

    modport master (
        output in_valid, x, cfg_we, cfg_addr, cfg_data, out_ready,
        input  in_ready, cfg_err, out_valid, y, busy
    );

    modport slave (
        input  in_valid, x, cfg_we, cfg_addr, cfg_data, out_ready,
        output in_ready, cfg_err, out_valid, y, busy
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - 4-tap FIR with one shared multiplier, one tap per cycle
module fir_seq_ctrl (
    input  logic         clk,
    input  logic         reset,
    fir_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t state, state_nxt;

    logic signed [7:0]  d [4];
    logic signed [7:0]  h [4];
    logic signed [15:0] acc;
    logic [1:0]         k;
    logic signed [15:0] y_q;
    logic               out_valid_q;
    logic               cfg_err_q;

    logic               accept;
    logic               cfg_apply;
    logic signed [15:0] prod;
    logic signed [15:0] sum;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign cfg_apply = (state == IDLE) && bus.cfg_we;

    // The single multiplier is time-shared across taps by indexing with k.
    assign prod = 16'(h[k]) * 16'(d[k]);
    assign sum  = acc + prod;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)            state_nxt = MAC;
            MAC:  if (k == 2'd3)         state_nxt = HOLD;
            HOLD: if (bus.out_ready)     state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d[0]        <= '0;
            d[1]        <= '0;
            d[2]        <= '0;
            d[3]        <= '0;
            h[0]        <= 8'sd2;
            h[1]        <= 8'sd4;
            h[2]        <= 8'sd4;
            h[3]        <= 8'sd2;
            acc         <= '0;
            k           <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            cfg_err_q <= bus.cfg_we && (state != IDLE);
            // Written before the MAC pass starts, so a same-edge sample uses the new value.
            if (cfg_apply) begin
                h[bus.cfg_addr] <= bus.cfg_data;
            end
            if (accept) begin
                d[3] <= d[2];
                d[2] <= d[1];
                d[1] <= d[0];
                d[0] <= bus.x;
                acc  <= '0;
                k    <= '0;
            end
            if (state == MAC) begin
                acc <= sum;
                k   <= k + 2'd1;
                if (k == 2'd3) begin
                    y_q         <= sum;
                    out_valid_q <= 1'b1;
                end
            end
            if ((state == HOLD) && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.y         = y_q;
    assign bus.out_valid = out_valid_q;
    assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - directed self-checking bench for fir_seq_ctrl with a behavioural model
module tb_fir_seq_ctrl;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fir_seq_ctrl_if bus();

    fir_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int got[$];
    int n_acc = 0;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int wrap16(input int v);
        int r;
        r = v & 32'hFFFF;
        if (r >= 32768) r = r - 65536;
        return r;
    endfunction

    // Model: a sample's result appears 4 edges after acceptance and holds until taken.
    int m_h[4]  = '{2, 4, 4, 2};
    int m_d[4]  = '{0, 0, 0, 0};
    int m_cnt   = 0;
    bit m_ov    = 1'b0;
    int m_y     = 0;
    bit m_err   = 1'b0;
    int m_pend  = 0;
    bit m_idle_now;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_h   = '{2, 4, 4, 2};
            m_d   = '{0, 0, 0, 0};
            m_cnt = 0;
            m_ov  = 1'b0;
            m_y   = 0;
            m_err = 1'b0;
        end else begin
            m_idle_now = (m_cnt == 0) && !m_ov;
            m_err = bus.cfg_we && !m_idle_now;
            if (m_idle_now && bus.cfg_we) m_h[bus.cfg_addr] = int'($signed(bus.cfg_data));
            if (m_idle_now && bus.in_valid) begin
                m_d[3] = m_d[2];
                m_d[2] = m_d[1];
                m_d[1] = m_d[0];
                m_d[0] = int'($signed(bus.x));
                m_pend = wrap16(m_h[0]*m_d[0] + m_h[1]*m_d[1] + m_h[2]*m_d[2] + m_h[3]*m_d[3]);
                m_cnt  = 4;
            end else if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_ov = 1'b1;
                    m_y  = m_pend;
                end
            end else if (m_ov && bus.out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            chk("in_ready",  bus.in_ready,  (m_cnt == 0) && !m_ov);
            chk("busy",      bus.busy,      !((m_cnt == 0) && !m_ov));
            chk("out_valid", bus.out_valid, m_ov);
            chk("y",         $signed(bus.y), m_y);
            chk("cfg_err",   bus.cfg_err,   m_err);
            if (bus.out_valid && bus.out_ready) got.push_back(int'($signed(bus.y)));
            if (bus.in_valid && bus.in_ready) n_acc++;
        end
    end

    task automatic send(input int v);
        int c;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = 8'(v);
        c = 0;
        while (!bus.in_ready && c < 100) begin
            @(negedge clk);
            c++;
        end
        if (c >= 100) chk("send_timeout", 1, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic cfg(input int a, input int v);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'(a);
        bus.cfg_data = 8'(v);
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        int c;
        c = 0;
        while (got.size() < exp.size() && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
        got.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e[$];
        int c;
        int acc0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_y",        $signed(bus.y), 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready",  bus.in_ready,  1);
        chk("rst_busy",      bus.busy,      0);
        chk("rst_cfg_err",   bus.cfg_err,   0);
        reset = 1'b0;

        send(1);
        c = 0;
        while (!bus.out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("latency", c, 4);
        repeat (4) send(0);
        e = '{2, 4, 4, 2, 0};
        check_seq("impulse", e);

        repeat (5) send(10);
        e = '{20, 60, 100, 120, 120};
        check_seq("step", e);

        repeat (4) send(0);
        e = '{100, 60, 20, 0};
        check_seq("flush", e);

        cfg(1, -3);
        send(1);
        repeat (4) send(0);
        e = '{2, -3, 4, 2, 0};
        check_seq("cfg_h1", e);

        send(1);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd0;
        bus.cfg_data = 8'sd7;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        chk("cfg_err_pulse", bus.cfg_err, 1);
        @(negedge clk);
        chk("cfg_err_clear", bus.cfg_err, 0);
        repeat (3) send(0);
        e = '{2, -3, 4, 2};
        check_seq("cfg_ignored", e);

        @(negedge clk);
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        send(5);
        bus.in_valid = 1'b1;
        bus.x        = 8'sd7;
        c = 0;
        while (!bus.out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("bp_result_seen", bus.out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_y",         $signed(bus.y), 10);
            chk("bp_in_ready",  bus.in_ready,  0);
            chk("bp_busy",      bus.busy,      1);
        end
        bus.out_ready = 1'b1;
        c = 0;
        while (!bus.in_ready && c < 20) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        e = '{10, -1};
        check_seq("backpressure", e);
        chk("bp_accepts", n_acc - acc0, 2);

        send(3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_y",         $signed(bus.y), 0);
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_busy",      bus.busy,      0);
        chk("arst_in_ready",  bus.in_ready,  1);
        @(negedge clk);
        reset = 1'b0;
        got.delete();
        repeat (10) @(negedge clk);
        chk("arst_no_stale", got.size(), 0);
        send(1);
        repeat (4) send(0);
        e = '{2, 4, 4, 2, 0};
        check_seq("arst_impulse", e);

        for (int i = 0; i < 4; i++) cfg(i, -128);
        repeat (4) send(-128);
        e = '{16384, -32768, -16384, 0};
        check_seq("wrap", e);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
